// File: rtl/mbus_mem_seq.sv
// mbus_mem_seq - MB20 memory sequencer behind the KL10 MBOX.
// Answers start/request cycles on ports A and B with acknowledge, read-data
// and write-data handshakes, and holds the 36-bit word store with parity.
module mbus_mem_seq #(
   parameter int unsigned MEMSIZE    = 256*1024,
   parameter int unsigned ACK_DELAY  = 2,
   parameter int unsigned DATA_DELAY = 3
) (
   input  logic         clk,
   input  logic         crobar,
   input  logic         startA,
   input  logic         startB,
   input  logic         rdRq,
   input  logic         wrRq,
   input  logic [0:3]   rq,
   input  logic [14:35] adr,
   input  logic         adrPar,
   input  logic         memReset,
   input  logic [0:35]  dOut,
   input  logic         parOut,
   input  logic         outValidA,
   input  logic         outValidB,
   output logic [0:35]  dIn,
   output logic         parIn,
   output logic         acknA,
   output logic         acknB,
   output logic         inValidA,
   output logic         inValidB,
   output logic         busy,
   output logic         adrParErr,
   output logic         dataParErr,
   output logic         protoErr
);

   localparam int unsigned AW = (MEMSIZE > 8) ? $clog2(MEMSIZE) : 3;
   localparam int unsigned BW = AW - 2;

   typedef enum logic [2:0] {IDLE, ACK, RD_WAIT, RD_XFER, WR_XFER} state_e;

   // First pending word at or after 'from', wrapping within the quadword.
   function automatic logic [1:0] next_idx(input logic [3:0] rem, input logic [1:0] from);
      logic [1:0] r;
      r = from;
      for (int k = 3; k >= 0; k--) begin
         if (rem[from + 2'(k)]) r = from + 2'(k);
      end
      return r;
   endfunction

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [3:0]      rem_q, rem_d;     // bit i set: word i still to transfer
   logic [1:0]      ptr_q, ptr_d;     // search start for the next word
   logic [BW-1:0]   base_q, base_d;   // quadword address
   logic            rd_q, rd_d;
   logic            portb_q, portb_d;
   logic            ack_a_q, ack_a_d, ack_b_q, ack_b_d;
   logic            iv_a_q, iv_a_d, iv_b_q, iv_b_d;
   logic [35:0]     din_q, din_d;
   logic            par_q, par_d;
   logic            busy_q, busy_d;
   logic            adr_perr_q, adr_perr_d;
   logic            dat_perr_q, dat_perr_d;
   logic            proto_q, proto_d;

   // Each entry is {inverted parity, data}: an all-zero entry reads back
   // as data 0 with good odd parity, so never-written words need no clearing.
   logic [36:0]     mem_q [MEMSIZE];
   logic            mem_we;
   logic [36:0]     mem_wdata;

   logic [1:0]      cur_idx;
   logic [AW-1:0]   cur_addr;
   logic [36:0]     cur_word;
   logic [3:0]      rem_left;
   logic            out_valid_sel;
   logic [AW-1:0]   adr_w;
   logic            emit;

   assign cur_idx       = next_idx(rem_q, ptr_q);
   assign cur_addr      = {base_q, cur_idx};
   assign cur_word      = mem_q[cur_addr];
   assign rem_left      = rem_q & ~(4'b0001 << cur_idx);
   assign out_valid_sel = portb_q ? outValidB : outValidA;
   assign adr_w         = AW'(adr);

   // Next-state, handshake and data-path decisions for the sequencer.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
      state_d    = state_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      ptr_d      = ptr_q;
      base_d     = base_q;
      rd_d       = rd_q;
      portb_d    = portb_q;
      ack_a_d    = 1'b0;
      ack_b_d    = 1'b0;
      iv_a_d     = 1'b0;
      iv_b_d     = 1'b0;
      din_d      = '0;
      par_d      = 1'b0;
      adr_perr_d = adr_perr_q;
      dat_perr_d = dat_perr_q;
      proto_d    = proto_q;
      mem_we     = 1'b0;
      mem_wdata  = {~parOut, dOut};
      emit       = 1'b0;

      if (memReset) begin
         state_d    = IDLE;
         adr_perr_d = 1'b0;
         dat_perr_d = 1'b0;
         proto_d    = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (startA || startB) begin
                  if (!(^{adr, adrPar})) adr_perr_d = 1'b1;
                  if (rdRq == wrRq)      proto_d    = 1'b1;
                  // Nonexistent memory is silently dropped; the MBOX times out.
                  if ((^{adr, adrPar}) && (rdRq != wrRq) && (32'(adr) < MEMSIZE)) begin
                     state_d = ACK;
                     cnt_d   = 4'(ACK_DELAY - 1);
                     base_d  = adr_w[AW-1:2];
                     ptr_d   = adr_w[1:0];
                     rem_d   = {rq[3], rq[2], rq[1], rq[0]};
                     rd_d    = rdRq;
                     portb_d = !startA;
                  end
               end
            end
            ACK: begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else if (ack_a_q || ack_b_q) begin
                  // Only an empty mask lingers here for its ack cycle.
                  state_d = IDLE;
               end else begin
                  ack_a_d = !portb_q;
                  ack_b_d = portb_q;
                  if (rem_q == 4'd0) begin
                     state_d = ACK;
                  end else if (rd_q) begin
                     state_d = RD_WAIT;
                     cnt_d   = 4'(DATA_DELAY - 1);
                  end else begin
                     state_d = WR_XFER;
                  end
               end
            end
            RD_WAIT: begin
               if (cnt_q != 4'd0) begin
                  cnt_d = cnt_q - 4'd1;
               end else begin
                  emit    = 1'b1;
                  state_d = RD_XFER;
               end
            end
            RD_XFER: begin
               if (rem_q == 4'd0) state_d = IDLE;
               else               emit    = 1'b1;
            end
            WR_XFER: begin
               if (out_valid_sel) begin
                  mem_we = 1'b1;
                  if (!(^{dOut, parOut})) dat_perr_d = 1'b1;
                  rem_d = rem_left;
                  ptr_d = cur_idx + 2'd1;
                  if (rem_left == 4'd0) state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      if (emit) begin
         din_d  = cur_word[35:0];
         par_d  = ~cur_word[36];
         iv_a_d = !portb_q;
         iv_b_d = portb_q;
         rem_d  = rem_left;
         ptr_d  = cur_idx + 2'd1;
      end

      busy_d = (state_d != IDLE);
   end

   // Control and output registers; crobar clears everything except the store.
   always_ff @(posedge clk or posedge crobar) begin
      if (crobar) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rem_q      <= '0;
         ptr_q      <= '0;
         base_q     <= '0;
         rd_q       <= 1'b0;
         portb_q    <= 1'b0;
         ack_a_q    <= 1'b0;
         ack_b_q    <= 1'b0;
         iv_a_q     <= 1'b0;
         iv_b_q     <= 1'b0;
         din_q      <= '0;
         par_q      <= 1'b0;
         busy_q     <= 1'b0;
         adr_perr_q <= 1'b0;
         dat_perr_q <= 1'b0;
         proto_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         ptr_q      <= ptr_d;
         base_q     <= base_d;
         rd_q       <= rd_d;
         portb_q    <= portb_d;
         ack_a_q    <= ack_a_d;
         ack_b_q    <= ack_b_d;
         iv_a_q     <= iv_a_d;
         iv_b_q     <= iv_b_d;
         din_q      <= din_d;
         par_q      <= par_d;
         busy_q     <= busy_d;
         adr_perr_q <= adr_perr_d;
         dat_perr_q <= dat_perr_d;
         proto_q    <= proto_d;
      end
   end

   // Word store write port.
   always_ff @(posedge clk) begin
      // NOTE: the store has no reset; contents must survive crobar and memReset.
      if (mem_we) mem_q[cur_addr] <= mem_wdata;
   end

   assign dIn        = din_q;
   assign parIn      = par_q;
   assign acknA      = ack_a_q;
   assign acknB      = ack_b_q;
   assign inValidA   = iv_a_q;
   assign inValidB   = iv_b_q;
   assign busy       = busy_q;
   assign adrParErr  = adr_perr_q;
   assign dataParErr = dat_perr_q;
   assign protoErr   = proto_q;

endmodule

// File: tb/tb_mbus_mem_seq.sv
// Directed bench for mbus_mem_seq with default parameters (ACK_DELAY=2, DATA_DELAY=3).
// Log index k holds outputs sampled 1ns after edge E+k, E being the start edge.
module tb_mbus_mem_seq;

   logic         clk = 1'b0;
   logic         crobar, startA, startB, rdRq, wrRq, adrPar, memReset;
   logic [0:3]   rq;
   logic [14:35] adr;
   logic [0:35]  dOut;
   logic         parOut, outValidA, outValidB;
   logic [0:35]  dIn;
   logic         parIn, acknA, acknB, inValidA, inValidB, busy;
   logic         adrParErr, dataParErr, protoErr;

   int checks = 0;
   int errors = 0;

   // Logged outputs: ctl = {acknA, acknB, inValidA, inValidB, busy}, dat = {parIn, dIn}.
   logic [4:0]  l_ctl [32];
   logic [36:0] l_dat [32];
   logic        l_dpe [32];
   // Per-cycle stimulus schedule driven by collect().
   logic        s_ova [32];
   logic        s_ovb [32];
   logic        s_sb  [32];
   logic        s_mr  [32];
   logic [35:0] s_dout [32];
   logic        s_par [32];

   always #5 clk = ~clk;

   mbus_mem_seq dut (
      .clk(clk), .crobar(crobar), .startA(startA), .startB(startB),
      .rdRq(rdRq), .wrRq(wrRq), .rq(rq), .adr(adr), .adrPar(adrPar),
      .memReset(memReset), .dOut(dOut), .parOut(parOut),
      .outValidA(outValidA), .outValidB(outValidB),
      .dIn(dIn), .parIn(parIn), .acknA(acknA), .acknB(acknB),
      .inValidA(inValidA), .inValidB(inValidB), .busy(busy),
      .adrParErr(adrParErr), .dataParErr(dataParErr), .protoErr(protoErr)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic snap(input int k);
      l_ctl[k] = {acknA, acknB, inValidA, inValidB, busy};
      l_dat[k] = {parIn, dIn};
      l_dpe[k] = dataParErr;
   endtask

   task automatic clear_sched();
      for (int i = 0; i < 32; i++) begin
         s_ova[i] = 1'b0; s_ovb[i] = 1'b0; s_sb[i] = 1'b0; s_mr[i] = 1'b0;
         s_dout[i] = '0;  s_par[i] = 1'b0;
      end
   endtask

   task automatic set_wr(input int k, input bit pb, input logic [35:0] d, input bit bad);
      if (pb) s_ovb[k] = 1'b1; else s_ova[k] = 1'b1;
      s_dout[k] = d;
      s_par[k]  = ~(^d) ^ bad;
   endtask

   task automatic start_req(input bit sa, input bit sb, input bit rd, input bit wr,
                            input logic [0:3] m, input logic [21:0] a, input bit bad);
      startA = sa; startB = sb; rdRq = rd; wrRq = wr; rq = m; adr = a;
      adrPar = ~(^a) ^ bad;
      cyc();
      startA = 1'b0; startB = 1'b0;
      snap(0);
   endtask

   task automatic collect(input int n);
      for (int k = 0; k < n; k++) begin
         outValidA = s_ova[k]; outValidB = s_ovb[k]; dOut = s_dout[k];
         parOut = s_par[k]; startB = s_sb[k]; memReset = s_mr[k];
         cyc();
         snap(k + 1);
      end
      outValidA = 1'b0; outValidB = 1'b0; startB = 1'b0; memReset = 1'b0;
   endtask

   task automatic test_reset();
      crobar = 1'b1; startA = 0; startB = 0; rdRq = 0; wrRq = 0; rq = '0; adr = '0;
      adrPar = 0; memReset = 0; dOut = '0; parOut = 0; outValidA = 0; outValidB = 0;
      #2;
      checks++;
      if ({acknA, acknB, inValidA, inValidB, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_ctl: got %b expected 00000", {acknA, acknB, inValidA, inValidB, busy});
      end
      checks++;
      if ({parIn, dIn} !== 37'd0) begin
         errors++; $display("FAIL reset_data: got %h expected 0", {parIn, dIn});
      end
      checks++;
      if ({adrParErr, dataParErr, protoErr} !== 3'b0) begin
         errors++; $display("FAIL reset_flags: got %b expected 000", {adrParErr, dataParErr, protoErr});
      end
      #2 crobar = 1'b0;
      cyc(); cyc();
      checks++;
      if ({acknA, acknB, inValidA, inValidB, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_idle: got %b expected 00000", {acknA, acknB, inValidA, inValidB, busy});
      end
   endtask

   task automatic test_write_quad();
      logic [4:0] exp_ctl;
      clear_sched();
      for (int i = 0; i < 4; i++) set_wr(3 + i, 1'b0, 36'(i + 1), 1'b0);
      start_req(1, 0, 0, 1, 4'b1111, 22'o1000, 0);
      collect(10);
      for (int k = 0; k <= 10; k++) begin
         exp_ctl = {k == 2, 1'b0, 1'b0, 1'b0, k <= 6};
         checks++;
         if (l_ctl[k] !== exp_ctl) begin
            errors++; $display("FAIL write_quad ctl[%0d]: got %b expected %b", k, l_ctl[k], exp_ctl);
         end
      end
   endtask

   task automatic test_read_quad(input string name, input bit both);
      logic [4:0]  exp_ctl;
      logic [35:0] d;
      logic [36:0] exp_dat;
      bit          v;
      clear_sched();
      if (both) begin s_sb[3] = 1'b1; s_sb[6] = 1'b1; end
      start_req(1, both, 1, 0, 4'b1111, 22'o1000, 0);
      collect(11);
      for (int k = 0; k <= 11; k++) begin
         v       = (k >= 5) && (k <= 8);
         d       = v ? 36'(k - 4) : 36'd0;
         exp_dat = v ? {~(^d), d} : 37'd0;
         exp_ctl = {k == 2, 1'b0, v, 1'b0, k <= 8};
         checks++;
         if (l_ctl[k] !== exp_ctl) begin
            errors++; $display("FAIL %s ctl[%0d]: got %b expected %b", name, k, l_ctl[k], exp_ctl);
         end
         checks++;
         if (l_dat[k] !== exp_dat) begin
            errors++; $display("FAIL %s data[%0d]: got %h expected %h", name, k, l_dat[k], exp_dat);
         end
      end
   endtask

   task automatic test_wrapped_read();
      logic [4:0]  exp_ctl;
      logic [36:0] exp_dat;
      clear_sched();
      start_req(0, 1, 1, 0, 4'b1010, 22'o1002, 0);
      collect(9);
      for (int k = 0; k <= 9; k++) begin
         exp_ctl = {1'b0, k == 2, 1'b0, (k == 5) || (k == 6), k <= 6};
         // word 2 holds 3 (parity 1), word 0 holds 1 (parity 0)
         exp_dat = (k == 5) ? {1'b1, 36'd3} : (k == 6) ? {1'b0, 36'd1} : 37'd0;
         checks++;
         if (l_ctl[k] !== exp_ctl) begin
            errors++; $display("FAIL wrapped_read ctl[%0d]: got %b expected %b", k, l_ctl[k], exp_ctl);
         end
         checks++;
         if (l_dat[k] !== exp_dat) begin
            errors++; $display("FAIL wrapped_read data[%0d]: got %h expected %h", k, l_dat[k], exp_dat);
         end
      end
   endtask

   task automatic test_no_words();
      logic [4:0] exp_ctl;
      clear_sched();
      start_req(1, 0, 1, 0, 4'b0000, 22'o1000, 0);
      collect(6);
      for (int k = 0; k <= 6; k++) begin
         exp_ctl = {k == 2, 1'b0, 1'b0, 1'b0, k <= 2};
         checks++;
         if (l_ctl[k] !== exp_ctl) begin
            errors++; $display("FAIL no_words ctl[%0d]: got %b expected %b", k, l_ctl[k], exp_ctl);
         end
      end
   endtask

   task automatic test_rejects();
      bit seen_ack;
      // bad address parity
      clear_sched();
      start_req(1, 0, 1, 0, 4'b1111, 22'o1000, 1);
      collect(6);
      seen_ack = 0;
      for (int k = 0; k <= 6; k++) if (l_ctl[k][4] || l_ctl[k][3]) seen_ack = 1;
      checks++;
      if (seen_ack !== 1'b0) begin errors++; $display("FAIL reject_adrpar ack: got 1 expected 0"); end
      checks++;
      if ({adrParErr, protoErr} !== 2'b10) begin
         errors++; $display("FAIL reject_adrpar flags: got %b expected 10", {adrParErr, protoErr});
      end
      // nonexistent memory: adr = MEMSIZE
      start_req(1, 0, 1, 0, 4'b1111, 22'o1000000, 0);
      collect(6);
      seen_ack = 0;
      for (int k = 0; k <= 6; k++) if (l_ctl[k][4] || l_ctl[k][3]) seen_ack = 1;
      checks++;
      if (seen_ack !== 1'b0) begin errors++; $display("FAIL reject_nxm ack: got 1 expected 0"); end
      checks++;
      if ({adrParErr, protoErr} !== 2'b10) begin
         errors++; $display("FAIL reject_nxm flags: got %b expected 10", {adrParErr, protoErr});
      end
      // both read and write requested
      start_req(0, 1, 1, 1, 4'b1111, 22'o1000, 0);
      collect(6);
      seen_ack = 0;
      for (int k = 0; k <= 6; k++) if (l_ctl[k][4] || l_ctl[k][3]) seen_ack = 1;
      checks++;
      if (seen_ack !== 1'b0) begin errors++; $display("FAIL reject_proto ack: got 1 expected 0"); end
      checks++;
      if ({adrParErr, protoErr} !== 2'b11) begin
         errors++; $display("FAIL reject_proto flags: got %b expected 11", {adrParErr, protoErr});
      end
      memReset = 1'b1;
      cyc();
      memReset = 1'b0;
      checks++;
      if ({adrParErr, dataParErr, protoErr} !== 3'b000) begin
         errors++; $display("FAIL memreset_flags: got %b expected 000", {adrParErr, dataParErr, protoErr});
      end
   endtask

   task automatic test_write_stall();
      logic [4:0]  exp_ctl;
      logic [35:0] d;
      logic [36:0] exp_dat;
      bit          v;
      clear_sched();
      set_wr(3, 0, 36'd5, 0);
      set_wr(4, 0, 36'd6, 0);
      set_wr(8, 1, 36'hFFFFFFFFF, 1);   // port B data must be ignored
      set_wr(15, 0, 36'd7, 1);          // bad parity, stored as received
      set_wr(16, 0, 36'd8, 0);
      start_req(1, 0, 0, 1, 4'b1111, 22'o2000, 0);
      collect(19);
      for (int k = 0; k <= 19; k++) begin
         exp_ctl = {k == 2, 1'b0, 1'b0, 1'b0, k <= 16};
         checks++;
         if (l_ctl[k] !== exp_ctl) begin
            errors++; $display("FAIL write_stall ctl[%0d]: got %b expected %b", k, l_ctl[k], exp_ctl);
         end
         checks++;
         if (l_dpe[k] !== (k >= 16)) begin
            errors++; $display("FAIL write_stall dataParErr[%0d]: got %b expected %b", k, l_dpe[k], k >= 16);
         end
      end
      clear_sched();
      start_req(1, 0, 1, 0, 4'b1111, 22'o2000, 0);
      collect(10);
      for (int k = 0; k <= 10; k++) begin
         v       = (k >= 5) && (k <= 8);
         d       = v ? 36'(k) : 36'd0;
         exp_dat = v ? {~(^d) ^ (k == 7), d} : 37'd0;
         checks++;
         if (l_dat[k] !== exp_dat) begin
            errors++; $display("FAIL stall_readback data[%0d]: got %h expected %h", k, l_dat[k], exp_dat);
         end
      end
   endtask

   task automatic test_mem_reset_abort();
      logic [4:0]  exp_ctl;
      logic [36:0] exp_dat;
      bit          v;
      clear_sched();
      s_mr[6] = 1'b1;
      start_req(1, 0, 1, 0, 4'b1111, 22'o2000, 0);
      collect(9);
      for (int k = 0; k <= 9; k++) begin
         v       = (k == 5) || (k == 6);
         exp_dat = (k == 5) ? {1'b1, 36'd5} : (k == 6) ? {1'b1, 36'd6} : 37'd0;
         exp_ctl = {k == 2, 1'b0, v, 1'b0, k <= 6};
         checks++;
         if (l_ctl[k] !== exp_ctl) begin
            errors++; $display("FAIL memreset_abort ctl[%0d]: got %b expected %b", k, l_ctl[k], exp_ctl);
         end
         checks++;
         if (l_dat[k] !== exp_dat) begin
            errors++; $display("FAIL memreset_abort data[%0d]: got %h expected %h", k, l_dat[k], exp_dat);
         end
         checks++;
         if (l_dpe[k] !== (k <= 6)) begin
            errors++; $display("FAIL memreset_abort dataParErr[%0d]: got %b expected %b", k, l_dpe[k], k <= 6);
         end
      end
   endtask

   task automatic test_crobar_abort();
      logic [4:0]  exp_ctl;
      logic [36:0] exp_dat;
      clear_sched();
      start_req(1, 0, 0, 1, 4'b1111, 22'o3000, 0);
      cyc(); cyc(); cyc();
      outValidA = 1'b1; dOut = 36'd9; parOut = ~(^36'd9);
      cyc();
      outValidA = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL crobar_pre busy: got %b expected 1", busy); end
      #2 crobar = 1'b1;
      #1;
      checks++;
      if ({acknA, acknB, inValidA, inValidB, busy, parIn, dIn} !== 42'd0) begin
         errors++; $display("FAIL crobar_outputs: got %h expected 0", {acknA, acknB, inValidA, inValidB, busy, parIn, dIn});
      end
      crobar = 1'b0;
      cyc();
      // fresh read of the one word captured before crobar
      start_req(1, 0, 1, 0, 4'b1000, 22'o3000, 0);
      collect(8);
      for (int k = 0; k <= 8; k++) begin
         exp_ctl = {k == 2, 1'b0, k == 5, 1'b0, k <= 5};
         exp_dat = (k == 5) ? {1'b1, 36'd9} : 37'd0;
         checks++;
         if (l_ctl[k] !== exp_ctl) begin
            errors++; $display("FAIL crobar_fresh ctl[%0d]: got %b expected %b", k, l_ctl[k], exp_ctl);
         end
         checks++;
         if (l_dat[k] !== exp_dat) begin
            errors++; $display("FAIL crobar_fresh data[%0d]: got %h expected %h", k, l_dat[k], exp_dat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_quad();
      test_read_quad("read_quad", 1'b0);
      test_wrapped_read();
      test_read_quad("simultaneous", 1'b1);
      test_no_words();
      test_rejects();
      test_write_stall();
      test_mem_reset_abort();
      test_crobar_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
